// File: rtl/router_pkg.sv
// router_pkg: shared definitions for the router packet source.
//   ADDR_W / LEN_W / DATA_W : header field widths (DATA_W = ADDR_W + LEN_W)
//   ILLEGAL_ADDR            : destination value the router has no FIFO for
//   state_t                 : packet source FSM states
//   pack_header()           : builds the {length, address} header byte
package router_pkg;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] ILLEGAL_ADDR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    PARITY
  } state_t;

  function automatic logic [DATA_W-1:0] pack_header(input logic [LEN_W-1:0]  len,
                                                    input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_src_if.sv
// router_pkt_src_if: request side and router side of the packet source.
//   start, dest_addr, pay_len, seed : packet request (driven by the user)
//   busy                            : router back-pressure
//   data_out, pkt_valid             : byte stream towards the router
//   tx_active, done, err            : status back to the user
//   inject_err                      : only with ROUTER_SRC_ERR_INJ_EN defined;
//                                     requests a deliberately wrong parity byte
// Modports: master = the packet source, slave = everything around it.
interface router_pkt_src_if;
  import router_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] dest_addr;
  logic [LEN_W-1:0]  pay_len;
  logic [DATA_W-1:0] seed;
  logic              busy;
`ifdef ROUTER_SRC_ERR_INJ_EN
  logic              inject_err;
`endif
  logic [DATA_W-1:0] data_out;
  logic              pkt_valid;
  logic              tx_active;
  logic              done;
  logic              err;

  modport master (
`ifdef ROUTER_SRC_ERR_INJ_EN
    input  inject_err,
`endif
    input  start, dest_addr, pay_len, seed, busy,
    output data_out, pkt_valid, tx_active, done, err
  );

  modport slave (
`ifdef ROUTER_SRC_ERR_INJ_EN
    output inject_err,
`endif
    output start, dest_addr, pay_len, seed, busy,
    input  data_out, pkt_valid, tx_active, done, err
  );

endinterface

// File: rtl/router_pkt_src.sv
// router_pkt_src: source end of the router packet protocol.
// On a legal start request it sends one packet -- header {len, addr},
// len payload bytes seed, seed+1, ... (wrapping), then one parity byte
// (XOR of header and payload) -- honouring the router's busy signal, and
// pulses done once the parity byte has been taken.  An illegal request
// (address 3 or length 0) only pulses err.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high; aborts any packet in flight
//   bus   : router_pkt_src_if.master (request, byte stream, status)
// Optional build macro ROUTER_SRC_ERR_INJ_EN adds bus.inject_err: when it
// is high with a legal start, that packet's parity byte is inverted.
// All outputs are registered.
module router_pkt_src
  import router_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  router_pkt_src_if.master bus
);

  if (DATA_W != ADDR_W + LEN_W) begin : g_width_check
    $error("router_pkt_src: DATA_W must equal ADDR_W + LEN_W");
  end

  state_t            state, state_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              vld_q, vld_nxt;
  logic              act_q, act_nxt;
  logic              done_q, done_nxt;
  logic              err_q, err_nxt;
  logic [LEN_W-1:0]  len_q, len_nxt;
  logic [LEN_W-1:0]  idx_q, idx_nxt;
  logic [DATA_W-1:0] seed_q, seed_nxt;
  logic [DATA_W-1:0] par_q, par_nxt;
  logic [DATA_W-1:0] pay_byte;
  logic [DATA_W-1:0] par_byte;
  logic              legal;
`ifdef ROUTER_SRC_ERR_INJ_EN
  logic              inj_q, inj_nxt;
`endif

  assign legal    = (bus.dest_addr != ILLEGAL_ADDR) && (bus.pay_len != '0);
  // Incrementing pattern; the add wraps modulo 2^DATA_W on purpose.
  assign pay_byte = seed_q + DATA_W'(idx_q);

`ifdef ROUTER_SRC_ERR_INJ_EN
  assign par_byte = inj_q ? ~par_q : par_q;
`else
  assign par_byte = par_q;
`endif

  always_comb begin
    state_nxt = state;
    data_nxt  = data_q;
    vld_nxt   = vld_q;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    len_nxt   = len_q;
    seed_nxt  = seed_q;
    idx_nxt   = idx_q;
    par_nxt   = par_q;
`ifdef ROUTER_SRC_ERR_INJ_EN
    inj_nxt   = inj_q;
`endif

    case (state)
      IDLE: begin
        data_nxt = '0;
        vld_nxt  = 1'b0;
        if (bus.start) begin
          if (legal) begin
            len_nxt   = bus.pay_len;
            seed_nxt  = bus.seed;
`ifdef ROUTER_SRC_ERR_INJ_EN
            inj_nxt   = bus.inject_err;
`endif
            data_nxt  = pack_header(bus.pay_len, bus.dest_addr);
            vld_nxt   = 1'b1;
            par_nxt   = pack_header(bus.pay_len, bus.dest_addr);
            idx_nxt   = '0;
            state_nxt = HEADER;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      // The byte on data_out is consumed only when busy is low; otherwise
      // everything holds via the defaults above.
      HEADER, PAYLOAD: begin
        if (!bus.busy) begin
          if (idx_q < len_q) begin
            data_nxt  = pay_byte;
            par_nxt   = par_q ^ pay_byte;
            idx_nxt   = idx_q + LEN_W'(1);
            state_nxt = PAYLOAD;
          end else begin
            data_nxt  = par_byte;
            vld_nxt   = 1'b0;
            state_nxt = PARITY;
          end
        end
      end

      PARITY: begin
        if (!bus.busy) begin
          data_nxt  = '0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Registered copy of "not idle" so it lines up with the state register.
    act_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      data_q <= '0;
      vld_q  <= 1'b0;
      act_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      len_q  <= '0;
      idx_q  <= '0;
      seed_q <= '0;
      par_q  <= '0;
`ifdef ROUTER_SRC_ERR_INJ_EN
      inj_q  <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      data_q <= data_nxt;
      vld_q  <= vld_nxt;
      act_q  <= act_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
      len_q  <= len_nxt;
      idx_q  <= idx_nxt;
      seed_q <= seed_nxt;
      par_q  <= par_nxt;
`ifdef ROUTER_SRC_ERR_INJ_EN
      inj_q  <= inj_nxt;
`endif
    end
  end

  assign bus.data_out  = data_q;
  assign bus.pkt_valid = vld_q;
  assign bus.tx_active = act_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
